// File: rtl/serial_addsub.sv
// ============================================================================
// Module   : serial_addsub
// Brief    : Digit-serial adder/subtractor, LSB first, DIGIT bits per cycle,
//            with valid/ready handshakes on operands and result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_addsub #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_psum;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [DIGIT-1:0] w_dsum;
    logic             w_c;
    logic             w_dcarry;
    logic             w_msb_cin;
    logic [WIDTH-1:0] w_psum_next;

    // Ripple through one digit; the carry entering the digit's top bit is
    // kept so overflow can be formed on the final digit.
    always_comb begin
        w_c       = r_carry;
        w_msb_cin = r_carry;
        w_dsum    = '0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                w_msb_cin = w_c;
            end
            w_dsum[i] = r_a[i] ^ r_b[i] ^ w_c;
            w_c       = (r_a[i] & r_b[i]) | (r_a[i] & w_c) | (r_b[i] & w_c);
        end
        w_dcarry = w_c;
    end

    assign w_psum_next = (r_psum >> DIGIT) | (WIDTH'(w_dsum) << (WIDTH - DIGIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_a     <= i_a;
                        r_b     <= i_sub ? ~i_b : i_b;
                        r_carry <= i_sub ? ~i_cin : i_cin;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_psum  <= w_psum_next;
                    r_carry <= w_dcarry;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == C_LAST) begin
                        r_sum   <= w_psum_next;
                        r_cout  <= w_dcarry;
                        r_ovf   <= w_msb_cin ^ w_dcarry;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready  = (r_state == S_IDLE);
    assign o_out_valid = (r_state == S_DONE);
    assign o_sum       = r_sum;
    assign o_cout      = r_cout;
    assign o_ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub.sv
// ============================================================================
// Module   : tb_serial_addsub
// Brief    : Self-checking bench for serial_addsub (DIGIT=1 and DIGIT=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;

    logic        rdy1, vld1, cout1, ovf1;
    logic        rdy8, vld8, cout8, ovf8;
    logic [31:0] sum1, sum8;

    logic        cur_rdy, cur_vld, cur_cout, cur_ovf;
    logic [31:0] cur_sum;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(32), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid & ~sel), .o_in_ready(rdy1),
        .i_a(a), .i_b(b), .i_cin(cin), .i_sub(sub),
        .o_out_valid(vld1), .i_out_ready(out_ready & ~sel),
        .o_sum(sum1), .o_cout(cout1), .o_ovf(ovf1)
    );

    serial_addsub #(.WIDTH(32), .DIGIT(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid & sel), .o_in_ready(rdy8),
        .i_a(a), .i_b(b), .i_cin(cin), .i_sub(sub),
        .o_out_valid(vld8), .i_out_ready(out_ready & sel),
        .o_sum(sum8), .o_cout(cout8), .o_ovf(ovf8)
    );

    assign cur_rdy  = sel ? rdy8  : rdy1;
    assign cur_vld  = sel ? vld8  : vld1;
    assign cur_sum  = sel ? sum8  : sum1;
    assign cur_cout = sel ? cout8 : cout1;
    assign cur_ovf  = sel ? ovf8  : ovf1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from integer arithmetic on the operands.
    function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mcin, input logic msub);
        longint    sa;
        longint    sb;
        longint    r;
        logic [32:0] u;
        logic      c;
        logic      o;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (!msub) begin
            u = {1'b0, ma} + {1'b0, mb} + 33'(mcin);
            c = u[32];
            r = sa + sb + longint'(mcin);
        end else begin
            u = {1'b0, ma} - {1'b0, mb} - 33'(mcin);
            c = ({1'b0, ma} >= ({1'b0, mb} + 33'(mcin)));
            r = sa - sb - longint'(mcin);
        end
        o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return {o, c, u[31:0]};
    endfunction

    // Entered just after a negedge with the selected DUT idle.
    task automatic run_op(input logic d, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tcin, input logic tsub, input int stall);
        logic [33:0] exp;
        int          lat;
        int          k;
        exp = model(ta, tb, tcin, tsub);
        lat = d ? 4 : 32;
        sel = d;
        a = ta; b = tb; cin = tcin; sub = tsub;
        in_valid = 1'b1;
        out_ready = 1'b0;
        check("in_ready_before_accept", 64'(cur_rdy), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!cur_vld && k <= lat + 5) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'($urandom);
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0;
        check("latency", 64'(k), 64'(lat));
        check("sum", 64'(cur_sum), 64'(exp[31:0]));
        check("cout", 64'(cur_cout), 64'(exp[32]));
        check("ovf", 64'(cur_ovf), 64'(exp[33]));
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom);
            a = $urandom; b = $urandom;
            @(negedge clk);
            check("stall_valid", 64'(cur_vld), 64'd1);
            check("stall_ready", 64'(cur_rdy), 64'd0);
            check("stall_result", {29'd0, cur_ovf, cur_cout, cur_sum}, {30'd0, exp});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_after_take", 64'(cur_vld), 64'd0);
        check("ready_after_take", 64'(cur_rdy), 64'd1);
        check("result_hold_idle", {29'd0, cur_ovf, cur_cout, cur_sum}, {30'd0, exp});
    endtask

    task automatic back_to_back();
        logic [33:0] q[$];
        logic [33:0] e;
        int          last;
        last = -1;
        sel = 1'b1;
        out_ready = 1'b1;
        for (int t = 0; t < 60; t++) begin
            if (cur_vld) begin
                if (q.size() == 0) begin
                    check("b2b_unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("b2b_result", {29'd0, cur_ovf, cur_cout, cur_sum}, {30'd0, e});
                end
            end
            in_valid = (t < 45);
            if (cur_rdy && in_valid) begin
                if (last >= 0) check("b2b_spacing", 64'(t - last), 64'd6);
                last = t;
                a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
                q.push_back(model(a, b, cin, sub));
            end
            @(negedge clk);
        end
        check("b2b_drained", 64'(q.size()), 64'd0);
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        int never;
        rst_n = 1'b0; sel = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        a = 32'hDEADBEEF; b = 32'h12345678; cin = 1'b1; sub = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(cur_rdy), 64'd1);
        check("rst_out_valid", 64'(cur_vld), 64'd0);
        check("rst_result", {29'd0, cur_ovf, cur_cout, cur_sum}, 64'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
        run_op(1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
        run_op(1'b0, 32'd5, 32'd7, 1'b0, 1'b1, 0);
        run_op(1'b0, 32'd7, 32'd5, 1'b1, 1'b1, 10);
        run_op(1'b0, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        // Abort an operation once cnt has reached 10.
        sel = 1'b0;
        a = 32'h11111111; b = 32'h22222222; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_in_ready", 64'(cur_rdy), 64'd1);
        check("midrst_out_valid", 64'(cur_vld), 64'd0);
        check("midrst_result", {29'd0, cur_ovf, cur_cout, cur_sum}, 64'd0);
        rst_n = 1'b1;
        never = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cur_vld) never++;
        end
        check("midrst_no_output", 64'(never), 64'd0);
        run_op(1'b0, 32'd3, 32'd4, 1'b0, 1'b0, 0);

        run_op(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
        run_op(1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 2);
        run_op(1'b1, 32'd5, 32'd7, 1'b0, 1'b1, 0);
        run_op(1'b1, 32'd7, 32'd5, 1'b1, 1'b1, 0);
        for (int i = 0; i < 6; i++) begin
            run_op(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end
        back_to_back();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
